// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared key-size encodings, round counts and FSM state type
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Both 1x encodings map to the 256-bit round count.
  function automatic logic [3:0] nr_of(input logic [1:0] sel);
    logic [3:0] nr;
    case (sel)
      KS_128:  nr = NR_128;
      KS_192:  nr = NR_192;
      default: nr = NR_256;
    endcase
    return nr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_scheduler_if
// Brief    : Requester, datapath-control and completion signals of the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface aes_round_scheduler_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_sel;
  logic [NREQ-1:0]   req_decrypt;
  logic              dp_load;
  logic              dp_round_en;
  logic [3:0]        dp_round_idx;
  logic [3:0]        dp_key_idx;
  logic              dp_last;
  logic              dp_decrypt;
  logic [1:0]        dp_sel;
  logic              done_valid;
  logic              done_ready;
  logic [ID_W-1:0]   done_id;
  logic              busy;

  modport master (
    output req_valid, req_sel, req_decrypt, done_ready,
    input  req_ready, dp_load, dp_round_en, dp_round_idx, dp_key_idx, dp_last,
    input  dp_decrypt, dp_sel, done_valid, done_id, busy
  );

  modport slave (
    input  req_valid, req_sel, req_decrypt, done_ready,
    output req_ready, dp_load, dp_round_en, dp_round_idx, dp_key_idx, dp_last,
    output dp_decrypt, dp_sel, done_valid, done_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : NREQ-way round-robin arbiter, lowest index at or after ptr wins
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  wire  [NREQ-1:0] i_req,
  input  wire  [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);

  logic [ID_W-1:0] w_hi_id;
  logic [ID_W-1:0] w_lo_id;
  logic            w_hi_any;
  logic            w_lo_any;

  // Descending scan leaves the lowest matching index in each candidate.
  always_comb begin
    w_hi_id  = '0;
    w_lo_id  = '0;
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_any = 1'b1;
        w_lo_id  = ID_W'(i);
        if (i >= int'(i_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_id  = ID_W'(i);
        end
      end
    end
  end

  assign o_any   = w_lo_any;
  assign o_id    = w_hi_any ? w_hi_id : w_lo_id;
  assign o_grant = w_lo_any ? (NREQ'(1) << o_id) : '0;

endmodule
`default_nettype wire

// File: rtl/aes_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_scheduler
// Brief    : Arbitrates AES jobs and sequences load/round/key-index controls
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input wire clk,
  input wire rst,
  aes_round_scheduler_if.slave bus
);

  localparam logic [ID_W-1:0] c_last_id = ID_W'(NREQ - 1);

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [3:0]      r_cnt;
  logic [3:0]      r_nr;
  logic [1:0]      r_sel;
  logic            r_dec;
  logic            r_load;
  logic            r_round_en;
  logic [3:0]      r_round_idx;
  logic [3:0]      r_key_idx;
  logic            r_last;
  logic            r_done_valid;

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_any;
  logic [1:0]      w_req_sel;
  logic [1:0]      w_sel_norm;
  logic            w_req_dec;
  logic [3:0]      w_req_nr;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id),
    .o_any   (w_any)
  );

  always_comb begin
    w_req_sel = '0;
    w_req_dec = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_req_sel = bus.req_sel[2*i +: 2];
        w_req_dec = bus.req_decrypt[i];
      end
    end
  end

  assign w_sel_norm = w_req_sel[1] ? KS_256 : w_req_sel;
  assign w_req_nr   = nr_of(w_sel_norm);
  assign w_accept   = (r_state == ST_IDLE) && w_any;
  assign w_cnt_nxt  = r_cnt + 4'd1;

  // Outputs are computed one cycle ahead so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_cnt        <= '0;
      r_nr         <= '0;
      r_sel        <= '0;
      r_dec        <= 1'b0;
      r_load       <= 1'b0;
      r_round_en   <= 1'b0;
      r_round_idx  <= '0;
      r_key_idx    <= '0;
      r_last       <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_LOAD;
            r_sel     <= w_sel_norm;
            r_dec     <= w_req_dec;
            r_id      <= w_gnt_id;
            r_nr      <= w_req_nr;
            r_load    <= 1'b1;
            r_key_idx <= w_req_dec ? w_req_nr : 4'd0;
          end
        end
        ST_LOAD: begin
          r_state     <= ST_ROUND;
          r_load      <= 1'b0;
          r_cnt       <= 4'd1;
          r_round_en  <= 1'b1;
          r_round_idx <= 4'd1;
          r_key_idx   <= r_dec ? (r_nr - 4'd1) : 4'd1;
          r_last      <= 1'b0;
        end
        ST_ROUND: begin
          if (r_cnt == r_nr) begin
            r_state      <= ST_DONE;
            r_round_en   <= 1'b0;
            r_round_idx  <= '0;
            r_key_idx    <= '0;
            r_last       <= 1'b0;
            r_done_valid <= 1'b1;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_round_idx <= w_cnt_nxt;
            r_key_idx   <= r_dec ? (r_nr - w_cnt_nxt) : w_cnt_nxt;
            r_last      <= (w_cnt_nxt == r_nr);
          end
        end
        ST_DONE: begin
          if (bus.done_ready) begin
            r_state      <= ST_IDLE;
            r_done_valid <= 1'b0;
            r_rr_ptr     <= (r_id == c_last_id) ? '0 : (r_id + 1'b1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == ST_IDLE) ? w_grant : '0;
  assign bus.dp_load      = r_load;
  assign bus.dp_round_en  = r_round_en;
  assign bus.dp_round_idx = r_round_idx;
  assign bus.dp_key_idx   = r_key_idx;
  assign bus.dp_last      = r_last;
  assign bus.dp_decrypt   = r_dec;
  assign bus.dp_sel       = r_sel;
  assign bus.done_valid   = r_done_valid;
  assign bus.done_id      = r_id;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Sequencing controller for a shared iterative AES round datapath (one round per clock). It accepts cipher jobs from NREQ requesters through round-robin arbitration and decodes each job's key size (128/192/256) into Nr = 10/12/14. It drives the datapath's load, round, round-key-index and last-round controls, then holds a completion handshake until the owner accepts it. It sits between the request front ends and the single round engine plus the KeyExpansion key store.

## Interface
- NREQ, 2: number of requesters (2..4)
- ID_W, 1: width of winner id, ≥ clog2(NREQ)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  job request per requester; held until accepted
- req_ready  out  NREQ  one-hot grant; accept = req_valid[i] & req_ready[i]
- req_sel  in  2*NREQ  key size per requester: 00→128, 01→192, 1x→256
- req_decrypt  in  NREQ  1 = inverse cipher
- dp_load  out  1  load state ← data XOR roundkey[dp_key_idx]
- dp_round_en  out  1  execute one round this cycle
- dp_round_idx  out  4  current round 1..Nr; 0 outside ROUND
- dp_key_idx  out  4  round-key index into expanded-key store
- dp_last  out  1  final round (MixColumns skipped)
- dp_decrypt  out  1  latched mode of active job
- dp_sel  out  2  latched key size of active job
- done_valid  out  1  result in datapath state register is final
- done_ready  in  1  owner consumes result
- done_id  out  ID_W  requester that owns the result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE
  - Grant = round-robin over req_valid, starting at pointer rr_ptr.
  - req_ready is combinational: asserted only in IDLE, only for the winner.
  - On accept: latch sel, decrypt and id; compute Nr; → LOAD.
  - No valid request: stay in IDLE.
- LOAD, one cycle
  - dp_load = 1.
  - dp_key_idx = 0 for encrypt, Nr for decrypt.
  - Round counter ← 1; → ROUND.
- ROUND
  - dp_round_en = 1; dp_round_idx = counter.
  - dp_key_idx = counter (encrypt) or Nr − counter (decrypt).
  - dp_last = (counter == Nr).
  - On last: → DONE; otherwise counter + 1.
- DONE
  - done_valid = 1 and done_id are held until done_ready.
  - On done_ready: rr_ptr ← (id + 1) mod NREQ; → IDLE.
- All dp_* strobes and done_valid are 0 outside their states. dp_sel, dp_decrypt and done_id hold their latched values until the next accept.
- req_sel = 11 is treated exactly as 10 (Nr = 14).
- Requests arriving during LOAD, ROUND or DONE wait; req_ready stays all-zero.

## Timing
- Reset (async assert, sync-safe release):
  - state = IDLE, rr_ptr = 0, counter = 0.
  - Latched sel/decrypt/id = 0.
  - All outputs 0.
- Accept at cycle t:
  - LOAD at t+1.
  - Rounds at t+2 .. t+Nr+1.
  - done_valid from t+Nr+2.
  - 128-bit: done at t+12; 192-bit: t+14; 256-bit: t+16.
- done_ready high at first DONE cycle: done_valid lasts exactly one cycle; IDLE for ≥ 1 cycle before the next accept. Minimum job spacing is Nr + 3 cycles.
- Simultaneous valid requests: the lowest index at or after rr_ptr wins; others keep waiting.
- Reset mid-job: the job is abandoned, with no done_valid. The requester must re-request.

## Structure
- Shared package aes_pkg holds:
  - NR_128 = 10, NR_192 = 12, NR_256 = 14.
  - Function nr_of(sel) → 4-bit Nr.
  - State enum.
  - Key-size encoding constants, shared with the top-level sel decode.
- One sub-module: rr_arbiter (NREQ-way round-robin, inputs req and ptr, output one-hot grant plus encoded id).
- FSM, counter and key-index arithmetic stay in aes_round_scheduler.

## Test plan
- Requester 0, sel = 00, encrypt, done_ready tied high:
  - accept at t; dp_load at t+1 with key_idx 0;
  - key_idx 1..10 over t+2..t+11, dp_last only at t+11;
  - done_valid at t+12, done_id = 0.
- Requester 1, sel = 01, decrypt:
  - LOAD key_idx 12;
  - ROUND key_idx 11,10,…,0, round_idx 1..12;
  - done at t+14, dp_decrypt = 1, dp_sel = 01.
- Both requesting continuously after reset:
  - grants alternate 0,1,0,1;
  - req_ready never has two bits set and is zero outside IDLE.
- sel = 11, done_ready low for 5 cycles:
  - 14 rounds, then done_valid held for 5 cycles;
  - IDLE entered the cycle after done_ready rises.
- rst asserted during round 4 of a 256-bit job:
  - all outputs 0 immediately, with no done_valid;
  - after release, a fresh request from 1 is granted first (rr_ptr = 0 but requester 0 idle).
